// File: rtl/imem_uart_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
// Holds the loader/receiver state encodings, the default frame marker and the checksum helper.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_LO = 3'd1,
    ST_CNT_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Running frame checksum: XOR of every data byte.
  function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] b);
    return chk ^ b;
  endfunction

endpackage

// File: rtl/imem_uart_loader_uart_rx.sv
// 8N1 UART receiver: double-flop synchroniser, half-bit start validation, centre sampling.
// Emits a one-cycle valid pulse per good byte, or a one-cycle frame_err pulse on a low stop bit.
module uart_rx
  import imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic            meta_r, sync_r, prev_r;
  rx_state_t       state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]      bit_idx_r;
  logic [7:0]      shift_r;
  logic            fall_s, half_tick_s, full_tick_s;
  logic            valid_s, ferr_s, sample_s;

  assign fall_s      = prev_r & ~sync_r;
  assign half_tick_s = (cnt_r == CNT_W'(CLKS_PER_BIT / 2 - 1));
  assign full_tick_s = (cnt_r == CNT_W'(CLKS_PER_BIT - 1));

  // Bring the asynchronous line into the clock domain; line idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
      prev_r <= 1'b1;
    end else begin
      meta_r <= rx;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RX_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Receiver next-state logic; a start bit that is high again at mid-bit is a glitch.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RX_IDLE: begin
        if (fall_s) state_next_s = RX_START;
        else        state_next_s = RX_IDLE;
      end
      RX_START: begin
        if (half_tick_s) state_next_s = sync_r ? RX_IDLE : RX_DATA;
        else             state_next_s = RX_START;
      end
      RX_DATA: begin
        if (full_tick_s && (bit_idx_r == 3'd7)) state_next_s = RX_STOP;
        else                                    state_next_s = RX_DATA;
      end
      RX_STOP: begin
        if (full_tick_s) state_next_s = RX_IDLE;
        else             state_next_s = RX_STOP;
      end
      default: state_next_s = RX_IDLE;
    endcase
  end

  // Receiver output decode for the stop-bit sampling point.
  always_comb begin
    sample_s = (state_r == RX_STOP) && full_tick_s;
    valid_s  = sample_s && sync_r;
    ferr_s   = sample_s && !sync_r;
  end

  // Bit timer, LSB-first shift register and registered byte outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
      data      <= 8'd0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= valid_s;
      frame_err <= ferr_s;
      if (valid_s) data <= shift_r;
      case (state_r)
        RX_IDLE: begin
          cnt_r     <= '0;
          bit_idx_r <= 3'd0;
        end
        RX_START: cnt_r <= half_tick_s ? '0 : cnt_r + CNT_W'(1);
        RX_DATA: begin
          if (full_tick_s) begin
            cnt_r     <= '0;
            shift_r   <= {sync_r, shift_r[7:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        RX_STOP: cnt_r <= full_tick_s ? '0 : cnt_r + CNT_W'(1);
        default: cnt_r <= '0;
      endcase
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// Boot loader: parses a framed, XOR-checksummed program image from UART and writes it into
// instruction memory, releasing the core from reset only after a fully verified load.
module imem_uart_loader
  import imem_loader_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         ADDR_W       = 8,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              load_error
);

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  logic [7:0]    rx_data_s;
  logic          rx_valid_s, rx_ferr_s;
  loader_state_t state_r, state_next_s;
  logic [7:0]    cnt_lo_r;
  logic [ADDR_W:0] count_r, word_idx_r;
  logic [1:0]    byte_idx_r;
  logic [23:0]   word_buf_r;
  logic [7:0]    chk_r;
  logic [15:0]   n_s;
  logic          is_sync_s, last_word_s;
  logic          clear_s, latch_lo_s, latch_hi_s, data_s, word_s;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (uart_rx),
    .data      (rx_data_s),
    .valid     (rx_valid_s),
    .frame_err (rx_ferr_s)
  );

  assign n_s         = {rx_data_s, cnt_lo_r};
  assign is_sync_s   = (rx_data_s == SYNC_BYTE);
  assign last_word_s = (byte_idx_r == 2'd3) && ((word_idx_r + (ADDR_W+1)'(1)) == count_r);

  // Loader state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Loader next-state logic; a framing error only matters once a frame has started.
  always_comb begin
    state_next_s = state_r;
    if (rx_ferr_s) begin
      case (state_r)
        ST_CNT_LO, ST_CNT_HI, ST_DATA, ST_CHECK: state_next_s = ST_ERROR;
        default:                                 state_next_s = state_r;
      endcase
    end else if (rx_valid_s) begin
      case (state_r)
        ST_IDLE:   state_next_s = is_sync_s ? ST_CNT_LO : ST_IDLE;
        ST_CNT_LO: state_next_s = ST_CNT_HI;
        ST_CNT_HI: begin
          if (n_s == 16'd0)                 state_next_s = ST_CHECK;
          else if ({1'b0, n_s} > MAX_WORDS) state_next_s = ST_ERROR;
          else                              state_next_s = ST_DATA;
        end
        ST_DATA:   state_next_s = last_word_s ? ST_CHECK : ST_DATA;
        ST_CHECK:  state_next_s = (rx_data_s == chk_r) ? ST_DONE : ST_ERROR;
        ST_DONE:   state_next_s = ST_DONE;
        ST_ERROR:  state_next_s = is_sync_s ? ST_CNT_LO : ST_ERROR;
        default:   state_next_s = ST_IDLE;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Per-byte datapath strobes decoded from the current state.
  always_comb begin
    clear_s    = rx_valid_s && is_sync_s && ((state_r == ST_IDLE) || (state_r == ST_ERROR));
    latch_lo_s = rx_valid_s && (state_r == ST_CNT_LO);
    latch_hi_s = rx_valid_s && (state_r == ST_CNT_HI);
    data_s     = rx_valid_s && (state_r == ST_DATA);
    word_s     = data_s && (byte_idx_r == 2'd3);
  end

  // Count capture, little-endian word assembly, checksum, write port and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_lo_r   <= 8'd0;
      count_r    <= '0;
      word_idx_r <= '0;
      byte_idx_r <= 2'd0;
      word_buf_r <= 24'd0;
      chk_r      <= 8'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      core_rst_n <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      imem_we    <= word_s;
      load_done  <= (state_next_s == ST_DONE);
      core_rst_n <= (state_next_s == ST_DONE);
      load_error <= (state_next_s == ST_ERROR);
      if (clear_s) begin
        word_idx_r <= '0;
        byte_idx_r <= 2'd0;
        chk_r      <= 8'd0;
      end
      if (latch_lo_s) cnt_lo_r <= rx_data_s;
      if (latch_hi_s) count_r  <= n_s[ADDR_W:0];
      if (data_s) begin
        chk_r      <= chk_update(chk_r, rx_data_s);
        byte_idx_r <= byte_idx_r + 2'd1;
        if (word_s) begin
          imem_wdata <= {rx_data_s, word_buf_r};
          imem_addr  <= word_idx_r[ADDR_W-1:0];
          word_idx_r <= word_idx_r + (ADDR_W+1)'(1);
        end else begin
          word_buf_r <= {rx_data_s, word_buf_r[23:8]};
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: two instances (ADDR_W=8 and ADDR_W=2), bit-banged 8N1
// frames with hand-computed words and checksums, immediate assertions at each check point.
module tb_imem_uart_loader;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_a = 1'b1;
  logic        rx_b = 1'b1;
  logic        we_a, core_a, done_a, err_a;
  logic [7:0]  addr_a;
  logic [31:0] wdata_a;
  logic        we_b, core_b, done_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;

  int tests = 0;
  int fails = 0;
  int wa_cnt = 0;
  int wb_cnt = 0;
  logic [7:0]  wa_addr_q[$];
  logic [31:0] wa_data_q[$];
  logic [1:0]  wb_addr_q[$];
  logic [31:0] wb_data_q[$];
  logic [7:0]  frame[$];
  int base;

  always #5 clk = ~clk;

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx_a), .imem_we(we_a), .imem_addr(addr_a),
    .imem_wdata(wdata_a), .core_rst_n(core_a), .load_done(done_a), .load_error(err_a)
  );

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx_b), .imem_we(we_b), .imem_addr(addr_b),
    .imem_wdata(wdata_b), .core_rst_n(core_b), .load_done(done_b), .load_error(err_b)
  );

  // Write-port monitor, one entry per cycle the strobe is high.
  always @(negedge clk) begin
    if (we_a) begin
      wa_cnt++;
      wa_addr_q.push_back(addr_a);
      wa_data_q.push_back(wdata_a);
    end
    if (we_b) begin
      wb_cnt++;
      wb_addr_q.push_back(addr_b);
      wb_data_q.push_back(wdata_b);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input bit stop_ok);
    drive(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive(sel, b[i]);
    drive(sel, stop_ok);
    drive(sel, 1'b1);
  endtask

  // Sends frame[0..nbytes-1]; the byte at bad_idx gets a low stop bit.
  task automatic send_frame(input bit sel, input int bad_idx, input int nbytes);
    for (int i = 0; i < nbytes; i++) send_byte(sel, frame[i], (i != bad_idx));
    repeat (8) @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check("rst_we", {31'd0, we_a}, 32'd0);
    check("rst_addr", {24'd0, addr_a}, 32'd0);
    check("rst_wdata", wdata_a, 32'd0);
    check("rst_core", {31'd0, core_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    check("rst_err", {31'd0, err_a}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: good two-word image
    frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00, 8'h70};
    base = wa_cnt;
    send_frame(1'b0, -1, 12);
    check("t1_nwr", wa_cnt - base, 32'd2);
    check("t1_addr0", {24'd0, wa_addr_q[base]}, 32'd0);
    check("t1_data0", wa_data_q[base], 32'h00A00513);
    check("t1_addr1", {24'd0, wa_addr_q[base+1]}, 32'd1);
    check("t1_data1", wa_data_q[base+1], 32'h00500593);
    check("t1_done", {31'd0, done_a}, 32'd1);
    check("t1_core", {31'd0, core_a}, 32'd1);
    check("t1_err", {31'd0, err_a}, 32'd0);

    // 2: bad checksum, then a clean reload
    reset_pulse();
    frame[11] = 8'h71;
    base = wa_cnt;
    send_frame(1'b0, -1, 12);
    check("t2_nwr", wa_cnt - base, 32'd2);
    check("t2_err", {31'd0, err_a}, 32'd1);
    check("t2_done", {31'd0, done_a}, 32'd0);
    check("t2_core", {31'd0, core_a}, 32'd0);
    frame[11] = 8'h70;
    base = wa_cnt;
    send_frame(1'b0, -1, 12);
    check("t2r_nwr", wa_cnt - base, 32'd2);
    check("t2r_addr0", {24'd0, wa_addr_q[base]}, 32'd0);
    check("t2r_data1", wa_data_q[base+1], 32'h00500593);
    check("t2r_err", {31'd0, err_a}, 32'd0);
    check("t2r_done", {31'd0, done_a}, 32'd1);
    check("t2r_core", {31'd0, core_a}, 32'd1);

    // 3: noise bytes and a one-clock glitch, then an empty image
    reset_pulse();
    base = wa_cnt;
    frame = '{8'h00, 8'hFF, 8'h12};
    send_frame(1'b0, -1, 3);
    rx_a = 1'b0;
    @(negedge clk);
    rx_a = 1'b1;
    repeat (20) @(negedge clk);
    check("t3_glitch_done", {31'd0, done_a}, 32'd0);
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame(1'b0, -1, 4);
    check("t3_nwr", wa_cnt - base, 32'd0);
    check("t3_done", {31'd0, done_a}, 32'd1);
    check("t3_err", {31'd0, err_a}, 32'd0);

    // 4: ADDR_W=2 oversize count, then a full four-word image
    frame = '{8'hA5, 8'h05, 8'h00};
    send_frame(1'b1, -1, 3);
    check("t4_over_err", {31'd0, err_b}, 32'd1);
    check("t4_over_nwr", wb_cnt, 32'd0);
    check("t4_over_core", {31'd0, core_b}, 32'd0);
    frame = '{8'hA5, 8'h04, 8'h00};
    for (int i = 1; i <= 16; i++) frame.push_back(8'(i));
    frame.push_back(8'h10);
    send_frame(1'b1, -1, 20);
    check("t4_nwr", wb_cnt, 32'd4);
    check("t4_addr0", {30'd0, wb_addr_q[0]}, 32'd0);
    check("t4_data0", wb_data_q[0], 32'h04030201);
    check("t4_addr3", {30'd0, wb_addr_q[3]}, 32'd3);
    check("t4_data2", wb_data_q[2], 32'h0C0B0A09);
    check("t4_data3", wb_data_q[3], 32'h100F0E0D);
    check("t4_done", {31'd0, done_b}, 32'd1);
    check("t4_err", {31'd0, err_b}, 32'd0);

    // 5: framing error on the third data byte
    reset_pulse();
    frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00, 8'h70};
    base = wa_cnt;
    send_frame(1'b0, 5, 6);
    check("t5_err", {31'd0, err_a}, 32'd1);
    check("t5_nwr", wa_cnt - base, 32'd0);
    check("t5_done", {31'd0, done_a}, 32'd0);

    // 6: reset mid-load, then reload from address 0
    reset_pulse();
    base = wa_cnt;
    send_frame(1'b0, -1, 8);
    check("t6_partial_nwr", wa_cnt - base, 32'd1);
    check("t6_partial_wdata", wdata_a, 32'h00A00513);
    rst_n = 1'b0;
    #1;
    check("t6_rst_we", {31'd0, we_a}, 32'd0);
    check("t6_rst_addr", {24'd0, addr_a}, 32'd0);
    check("t6_rst_wdata", wdata_a, 32'd0);
    check("t6_rst_core", {31'd0, core_a}, 32'd0);
    check("t6_rst_done", {31'd0, done_a}, 32'd0);
    check("t6_rst_err", {31'd0, err_a}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    base = wa_cnt;
    send_frame(1'b0, -1, 12);
    check("t6_nwr", wa_cnt - base, 32'd2);
    check("t6_addr0", {24'd0, wa_addr_q[base]}, 32'd0);
    check("t6_data0", wa_data_q[base], 32'h00A00513);
    check("t6_data1", wa_data_q[base+1], 32'h00500593);
    check("t6_done", {31'd0, done_a}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
